// File: rtl/serial_pkg.sv
// Types and constants shared by the serial link transmitter and receiver.
package serial_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/shift_reg.sv
// Purpose: loadable shift register that moves bits toward the serial output end, zero fill.
// Latency: a load or shift is visible on q one cycle after the enabling edge.
// Backpressure: none; load takes priority over shift, and q holds when neither is set.
module shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_next;
    logic             d_en;

    always_comb begin
        d_next = q;
        if (load) begin
            d_next = din;
        end else if (MSB_FIRST) begin
            d_next = {q[WIDTH-2:0], 1'b0};
        end else begin
            d_next = {1'b0, q[WIDTH-1:1]};
        end
    end

    assign d_en = load | shift;

    // Bank of D flip-flops sharing one enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (d_en) begin
            q <= d_next;
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Purpose: parallel-in/serial-out transmitter, one bit per enabled clock with valid/last flags.
// Latency: first bit on sout the cycle after the accepting edge; WIDTH enabled cycles per word.
// Backpressure: load_ready only when enabled and idle or on the last bit; en=0 freezes all state.
module piso_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic             accept;
    logic             advance;

    assign accept  = load_valid & load_ready;
    assign advance = en & busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An accept on the last bit reloads without passing through IDLE.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = SHIFT;
        end else if (en && state == SHIFT && last) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        busy       = (state == SHIFT);
        sout_valid = busy;
        last       = busy && (cnt == CNT_LAST);
        load_ready = en && (!busy || last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (advance),
        .din   (din),
        .q     (shreg)
    );

    assign sout = busy & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances against a bit-index reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b1;

    logic       lv  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       lr, sout, sv, last, busy;

    logic       lv2  = 1'b0;
    logic [7:0] din2 = 8'h00;
    logic       lr2, sout2, sv2, last2, busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (lv),
        .din        (din),
        .load_ready (lr),
        .sout       (sout),
        .sout_valid (sv),
        .last       (last),
        .busy       (busy)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load_valid (lv2),
        .din        (din2),
        .load_ready (lr2),
        .sout       (sout2),
        .sout_valid (sv2),
        .last       (last2),
        .busy       (busy2)
    );

    // Bit i of a frame (i = 0 is transmitted first).
    function automatic logic ref_bit(input logic [7:0] w, input int i, input bit msb);
        return msb ? w[7-i] : w[i];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed vector order: {sout, sout_valid, last, busy, load_ready}
    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b1;
        lv  = 1'b0;
        #3;
        total++;
        if ({sout, sv, last, busy, lr} !== 5'b00001) begin
            bad++;
            $display("FAIL reset got=%b want=00001", {sout, sv, last, busy, lr});
        end
        total++;
        if ({sout2, sv2, last2, busy2, lr2} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_lsb got=%b want=00001", {sout2, sv2, last2, busy2, lr2});
        end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_single(input logic [7:0] w);
        lv  = 1'b1;
        din = w;
        #1;
        total++;
        if (lr !== 1'b1) begin
            bad++;
            $display("FAIL single_ready w=%h got=%b want=1", w, lr);
        end
        step();
        lv  = 1'b0;
        din = $urandom;
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({sout, sv, last, busy, lr} !== {ref_bit(w, i, 1'b1), 1'b1, i == 7, 1'b1, i == 7}) begin
                bad++;
                $display("FAIL single w=%h bit=%0d got=%b want=%b", w, i,
                         {sout, sv, last, busy, lr}, {ref_bit(w, i, 1'b1), 1'b1, i == 7, 1'b1, i == 7});
            end
            step();
        end
        total++;
        if ({sout, sv, last, busy, lr} !== 5'b00001) begin
            bad++;
            $display("FAIL single_end w=%h got=%b want=00001", w, {sout, sv, last, busy, lr});
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] w0, input logic [7:0] w1);
        logic [7:0] w;
        lv  = 1'b1;
        din = w0;
        #1;
        total++;
        if (lr !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle_ready got=%b want=1", lr);
        end
        step();
        din = w1;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) lv = 1'b0;
            w = (i < 8) ? w0 : w1;
            total++;
            if ({sout, sv, last, busy, lr} !== {ref_bit(w, i % 8, 1'b1), 1'b1, (i % 8) == 7, 1'b1, (i % 8) == 7}) begin
                bad++;
                $display("FAIL b2b w0=%h w1=%h cyc=%0d got=%b want=%b", w0, w1, i,
                         {sout, sv, last, busy, lr}, {ref_bit(w, i % 8, 1'b1), 1'b1, (i % 8) == 7, 1'b1, (i % 8) == 7});
            end
            step();
        end
        total++;
        if ({sv, busy} !== 2'b00) begin
            bad++;
            $display("FAIL b2b_end got=%b want=00", {sv, busy});
        end
    endtask

    // Two-cycle enable stall starting while bit k is on the line.
    task automatic test_stall(input logic [7:0] w, input int k);
        int idx;
        int cyc;
        lv  = 1'b1;
        din = w;
        step();
        lv  = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 8 && cyc < 20) begin
            en = !(idx == k && (cyc == k || cyc == k + 1));
            #1;
            total++;
            if ({sout, sv, last, busy, lr} !== {ref_bit(w, idx, 1'b1), 1'b1, idx == 7, 1'b1, en && idx == 7}) begin
                bad++;
                $display("FAIL stall w=%h k=%0d cyc=%0d got=%b want=%b", w, k, cyc,
                         {sout, sv, last, busy, lr}, {ref_bit(w, idx, 1'b1), 1'b1, idx == 7, 1'b1, en && idx == 7});
            end
            if (en) idx++;
            cyc++;
            step();
        end
        en = 1'b1;
        total++;
        if (cyc !== 10 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_len w=%h got=%0d cycles busy=%b want=10 cycles busy=0", w, cyc, busy);
        end
    endtask

    task automatic test_lsb(input logic [7:0] w);
        lv2  = 1'b1;
        din2 = w;
        step();
        lv2  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({sout2, sv2, last2, busy2} !== {ref_bit(w, i, 1'b0), 1'b1, i == 7, 1'b1}) begin
                bad++;
                $display("FAIL lsb w=%h bit=%0d got=%b want=%b", w, i,
                         {sout2, sv2, last2, busy2}, {ref_bit(w, i, 1'b0), 1'b1, i == 7, 1'b1});
            end
            step();
        end
        total++;
        if ({sout2, sv2, busy2} !== 3'b000) begin
            bad++;
            $display("FAIL lsb_end got=%b want=000", {sout2, sv2, busy2});
        end
    endtask

    task automatic test_busy_reject(input logic [7:0] w1);
        lv  = 1'b1;
        din = 8'h00;
        step();
        lv  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                lv  = 1'b1;
                din = w1;
            end
            if (i == 8) lv = 1'b0;
            #1;
            total++;
            if ({sout, sv, last, lr} !== {(i < 8) ? 1'b0 : ref_bit(w1, i - 8, 1'b1), 1'b1, (i % 8) == 7, (i % 8) == 7}) begin
                bad++;
                $display("FAIL busy_reject cyc=%0d got=%b want=%b", i,
                         {sout, sv, last, lr}, {(i < 8) ? 1'b0 : ref_bit(w1, i - 8, 1'b1), 1'b1, (i % 8) == 7, (i % 8) == 7});
            end
            step();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_reject_end got=%b want=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        lv  = 1'b1;
        din = 8'hFF;
        step();
        lv  = 1'b0;
        repeat (5) step();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({sout, sv, last, busy, lr} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_mid got=%b want=00001", {sout, sv, last, busy, lr});
        end
        #2;
        rst = 1'b1;
        step();
        total++;
        if ({sout, sv, busy, lr} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_release got=%b want=0001", {sout, sv, busy, lr});
        end
        test_single(8'h5A);
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
        repeat (3) test_single(8'($urandom));
        step();
        test_back_to_back(8'hA5, 8'h3C);
        test_back_to_back(8'($urandom), 8'($urandom));
        step();
        test_stall(8'hA5, 2);
        for (int r = 0; r < 3; r++) test_stall(8'($urandom), int'($urandom_range(0, 7)));
        step();
        test_lsb(8'h01);
        test_lsb(8'($urandom));
        test_busy_reject(8'hFF);
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
